// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : router_fsm
//  Purpose  : Packet-level control FSM for a 1x3 router. Tracks the header,
//             payload and parity phases of each incoming packet, picks the
//             destination FIFO, and drives load strobes / write enable to the
//             register and sync blocks. Handles destination-busy waiting,
//             FIFO-full back-pressure and per-FIFO soft-reset abort.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in  system clock, rising edge
//    resetn         in  asynchronous active-low reset
//    pkt_valid      in  header/payload bytes present on input bus
//    data_in[1:0]   in  header address field
//    fifo_full      in  full flag of addressed FIFO
//    fifo_empty_0/1/2  in  per-FIFO empty flags
//    soft_reset_0/1/2  in  per-FIFO timeout abort pulses
//    parity_done    in  parity byte loaded by register block
//    low_pkt_valid  in  pkt_valid fell while FIFO was full
//    detect_add     out header cycle, sync block latches address
//    lfd_state      out load-first-data strobe
//    ld_state       out load-payload strobe
//    laf_state      out load-after-full strobe
//    full_state     out destination full, input stalled
//    write_enb_reg  out write-enable request to sync block
//    rst_int_reg    out clear internal parity-error register
//    busy           out source must hold input byte
// ============================================================================
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // Address 3 is not a valid destination; bit 3 of these vectors is tied
  // low so a 2-bit index never falls outside the vector.
  logic [3:0] empty_vec;
  logic [3:0] sreset_vec;
  logic       hdr_valid;
  logic       abort;

  assign empty_vec  = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign sreset_vec = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_valid  = pkt_valid && (data_in != 2'd3);
  // Only the FIFO this packet is bound to may abort it.
  assign abort      = sreset_vec[addr_q];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;

    case (state_q)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        if (hdr_valid) begin
          addr_d  = data_in;
          // Destination chosen from the live header, not the stale addr_q.
          state_d = empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
        state_d   = LOAD_DATA;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
        state_d       = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
        state_d     = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        busy = 1'b1;
        if (empty_vec[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // Soft-reset abort takes priority over every transition above.
    if ((state_q != DECODE_ADDRESS) && abort) state_d = DECODE_ADDRESS;
  end

endmodule
`default_nettype wire
